// File: rtl/cpu_port_responder.sv
// CPU-side memory responder: latches a request, answers after a fixed wait and hand-shakes on cpuena.
// Optional macro CPU_RESP_BURST_EN adds a one-word prefetch that shortens the follow-up of a longword read.

module cpu_port_responder #(
  parameter int ADDR_BITS  = 26,
  parameter int DEPTH_BITS = 10,
  parameter int WAIT       = 3
) (
  input  logic                   sysclk,
  input  logic                   reset_in,
  input  logic                   clk28_en,
  input  logic [ADDR_BITS-1:1]   cpuAddr,
  input  logic [3:0]             cpustate,
  input  logic                   cpuL,
  input  logic                   cpuU,
  input  logic [15:0]            cpuWR,
  output logic [15:0]            cpuRD,
  output logic                   cpuena,
  output logic [15:0]            acc_count
);

  // state   | meaning
  // IDLE    | waiting for a request on a clk28_en cycle
  // BUSY    | wait counter running down, access in flight
  // DONE    | cpuena high until the CPU side samples it with clk28_en
  // HOLDOFF | waiting for the request to drop before re-arming
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_HOLDOFF} state_t;

  localparam int         DEPTH     = 1 << DEPTH_BITS;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT - 1);

  state_t                r_state;
  state_t                w_next;
  logic [15:0]           r_mem [DEPTH];
  logic [DEPTH_BITS-1:0] r_idx;
  logic [1:0]            r_kind;
  logic                  r_l_n;
  logic                  r_u_n;
  logic [15:0]           r_wdata;
  logic [3:0]            r_wait;
  logic [15:0]           r_rd;
  logic [15:0]           r_acc;

  logic                  w_req;
  logic                  w_release;
  logic                  w_accept;
  logic                  w_complete;
  logic                  w_ack;
  logic                  w_is_write;
  logic                  w_hit;
  logic [DEPTH_BITS-1:0] w_idx_in;
  logic [15:0]           w_rd_data;
  logic                  w_unused;

  assign w_idx_in   = cpuAddr[DEPTH_BITS:1];
  assign w_req      = clk28_en && !cpustate[2] && (cpustate[1:0] != 2'b01);
  assign w_release  = clk28_en && (cpustate[2] || (cpustate[1:0] == 2'b01));
  assign w_is_write = (r_kind == 2'b11);
  // Upper address bits alias by design; longword flag only matters with prefetch.
  assign w_unused   = ^{cpustate[3], cpuAddr[ADDR_BITS-1:DEPTH_BITS+1]};

  always_ff @(posedge sysclk) begin
    if (reset_in) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_req) w_next = S_BUSY;
      S_BUSY:    if (r_wait == '0) w_next = S_DONE;
      S_DONE:    if (clk28_en) w_next = S_HOLDOFF;
      S_HOLDOFF: if (w_release) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cpuena     = 1'b0;
    w_accept   = 1'b0;
    w_complete = 1'b0;
    w_ack      = 1'b0;
    case (r_state)
      S_IDLE: w_accept = w_req;
      S_BUSY: w_complete = (r_wait == '0);
      S_DONE: begin
        cpuena = 1'b1;
        w_ack  = clk28_en;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset_in) begin
      r_wait  <= '0;
      r_rd    <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_kind  <= 2'b01;
      r_l_n   <= 1'b1;
      r_u_n   <= 1'b1;
      r_wdata <= '0;
    end else begin
      if (w_accept) begin
        r_idx   <= w_idx_in;
        r_kind  <= cpustate[1:0];
        r_l_n   <= cpuL;
        r_u_n   <= cpuU;
        r_wdata <= cpuWR;
        r_wait  <= w_hit ? 4'd0 : WAIT_LOAD;
      end else if ((r_state == S_BUSY) && (r_wait != '0)) begin
        r_wait <= r_wait - 1'b1;
      end
      if (w_complete && !w_is_write) r_rd <= w_rd_data;
      if (w_ack) r_acc <= r_acc + 1'b1;
    end
  end

  // No reset on the array: contents survive reset, and a reset in BUSY blocks the commit.
  always_ff @(posedge sysclk) begin
    if (!reset_in && w_complete && w_is_write) begin
      if (!r_l_n) r_mem[r_idx][7:0]  <= r_wdata[7:0];
      if (!r_u_n) r_mem[r_idx][15:8] <= r_wdata[15:8];
    end
  end

`ifdef CPU_RESP_BURST_EN
  logic                  r_pf_valid;
  logic                  r_use_pf;
  logic                  r_long;
  logic [DEPTH_BITS-1:0] r_pf_idx;
  logic [15:0]           r_pf_data;
  logic [DEPTH_BITS-1:0] w_idx_nxt;

  assign w_idx_nxt = r_idx + 1'b1;
  assign w_hit     = r_pf_valid && (r_pf_idx == w_idx_in) && !cpustate[0];
  assign w_rd_data = r_use_pf ? r_pf_data : r_mem[r_idx];

  // Any accepted access consumes or drops the prefetch, which also covers writes to it.
  always_ff @(posedge sysclk) begin
    if (reset_in) begin
      r_pf_valid <= 1'b0;
      r_use_pf   <= 1'b0;
      r_long     <= 1'b0;
      r_pf_idx   <= '0;
      r_pf_data  <= '0;
    end else if (w_accept) begin
      r_pf_valid <= 1'b0;
      r_use_pf   <= w_hit;
      r_long     <= cpustate[3];
    end else if (w_complete && !w_is_write && r_long && !r_idx[0]) begin
      r_pf_valid <= 1'b1;
      r_pf_idx   <= w_idx_nxt;
      r_pf_data  <= r_mem[w_idx_nxt];
    end
  end
`else
  assign w_hit     = 1'b0;
  assign w_rd_data = r_mem[r_idx];
`endif

  assign cpuRD     = r_rd;
  assign acc_count = r_acc;

endmodule

// File: tb/tb_cpu_port_responder.sv
// Scoreboard bench for cpu_port_responder: driver pushes expected completions, a negedge monitor pops them.
// Reference model is a plain word array plus a completion counter and (burst build) a prefetch tag.

module tb_cpu_port_responder;
  localparam int WAIT  = 3;
  localparam int DEPTH = 1024;

  logic        sysclk   = 1'b0;
  logic        reset_in = 1'b1;
  logic        clk28_en = 1'b0;
  logic [25:1] cpuAddr  = '0;
  logic [3:0]  cpustate = 4'b0101;
  logic        cpuL     = 1'b1;
  logic        cpuU     = 1'b1;
  logic [15:0] cpuWR    = '0;
  logic [15:0] cpuRD;
  logic        cpuena;
  logic [15:0] acc_count;

  cpu_port_responder #(.ADDR_BITS(26), .DEPTH_BITS(10), .WAIT(WAIT)) dut (
    .sysclk(sysclk), .reset_in(reset_in), .clk28_en(clk28_en), .cpuAddr(cpuAddr),
    .cpustate(cpustate), .cpuL(cpuL), .cpuU(cpuU), .cpuWR(cpuWR),
    .cpuRD(cpuRD), .cpuena(cpuena), .acc_count(acc_count)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc++;

  typedef struct {
    logic [15:0] data;
    int          acc_cyc;
    int          lat;
    logic [15:0] cnt;
  } item_t;

  item_t       sb[$];
  item_t       mon_it;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] mem_m [DEPTH];
  logic [15:0] last_rd = '0;
  logic [15:0] exp_cnt = '0;
  bit          pf_v    = 1'b0;
  int          pf_i    = 0;
  logic        prev_ena = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic summary_and_abort(input string what);
    n_checks++;
    $display("FAIL %s: got no response, expected one within the cycle budget", what);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "bench stopped");
  endtask

  always @(negedge sysclk) begin
    if (cpuena === 1'b1 && prev_ena !== 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_cpuena: got cpuena=1, expected no pending access (cycle %0d)", cyc);
      end else begin
        mon_it = sb.pop_front();
        chk("latency", 32'(cyc - mon_it.acc_cyc), 32'(mon_it.lat));
        chk("cpuRD", 32'(cpuRD), 32'(mon_it.data));
        chk("acc_count_at_cpuena", 32'(acc_count), 32'(mon_it.cnt));
      end
    end
    prev_ena = cpuena;
  end

  task automatic model_reset();
    exp_cnt = '0;
    last_rd = '0;
    pf_v    = 1'b0;
    sb.delete();
  endtask

  task automatic do_reset();
    @(posedge sysclk); #1;
    reset_in = 1'b1;
    cpustate = 4'b0101;
    clk28_en = 1'($urandom % 2);
    @(posedge sysclk); #1;
    reset_in = 1'b0;
    model_reset();
    @(negedge sysclk);
    chk("reset_cpuena", 32'(cpuena), 0);
    chk("reset_cpuRD", 32'(cpuRD), 0);
    chk("reset_acc_count", 32'(acc_count), 0);
  endtask

  // One full handshake; hold = cycles cpuena is left unacknowledged, keep = cycles the request stays asserted after ack.
  task automatic do_access(input logic [1:0] kind, input int w, input bit l_n, input bit u_n,
                           input logic [15:0] wd, input bit lng, input int hold, input int keep);
    item_t       it;
    int          idx;
    bit          got;
    bit          ok;
    logic [15:0] old;
    idx = w % DEPTH;
    @(posedge sysclk); #1;
    clk28_en = 1'b1;
    cpuAddr  = 25'(w);
    cpustate = {lng, 1'b0, kind};
    cpuL     = l_n;
    cpuU     = u_n;
    cpuWR    = wd;
    it.acc_cyc = cyc + 1;
    it.cnt     = exp_cnt;
    it.lat     = WAIT;
`ifdef CPU_RESP_BURST_EN
    if (pf_v && pf_i == idx && kind != 2'b11) it.lat = 1;
    pf_v = 1'b0;
    if (kind != 2'b11 && lng && (idx % 2 == 0)) begin
      pf_v = 1'b1;
      pf_i = (idx + 1) % DEPTH;
    end
`endif
    if (kind == 2'b11) begin
      old = mem_m[idx];
      mem_m[idx] = {u_n ? old[15:8] : wd[15:8], l_n ? old[7:0] : wd[7:0]};
      it.data = last_rd;
    end else begin
      it.data = mem_m[idx];
      last_rd = mem_m[idx];
    end
    sb.push_back(it);
    @(posedge sysclk); #1;
    cpuAddr = 25'($urandom);
    cpuWR   = 16'($urandom);
    cpuL    = 1'($urandom % 2);
    cpuU    = 1'($urandom % 2);
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge sysclk);
      if (cpuena === 1'b1) got = 1'b1;
      else clk28_en = 1'($urandom % 2);
    end
    if (!got) summary_and_abort("cpuena_timeout");
    if (hold > 0) begin
      clk28_en = 1'b0;
      ok = 1'b1;
      repeat (hold) begin
        @(negedge sysclk);
        if (cpuena !== 1'b1 || acc_count !== exp_cnt) ok = 1'b0;
      end
      chk("cpuena_held_without_clk28_en", 32'(ok), 1);
    end
    clk28_en = 1'b1;
    @(posedge sysclk);
    exp_cnt++;
    #1;
    if (keep == 0) cpustate[2] = 1'b1;
    @(negedge sysclk);
    chk("ack_cpuena_low", 32'(cpuena), 0);
    chk("ack_acc_count", 32'(acc_count), 32'(exp_cnt));
    if (keep > 0) begin
      repeat (keep) @(negedge sysclk);
      chk("holdoff_no_reaccept", 32'({cpuena, acc_count}), 32'({1'b0, exp_cnt}));
      cpustate[2] = 1'b1;
    end
    @(posedge sysclk); #1;
    clk28_en = 1'($urandom % 2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of run, expected completion within 2 ms");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "bench stopped");
  end

  initial begin
    repeat (3) @(posedge sysclk);
    do_reset();

    // basic write then read
    do_access(2'b11, 'h10, 1'b0, 1'b0, 16'hA55A, 1'b0, 0, 0);
    do_access(2'b10, 'h10, 1'b1, 1'b1, 16'h0000, 1'b0, 0, 0);
    chk("acc_count_after_two", 32'(acc_count), 2);

    // byte enables
    do_access(2'b11, 'h20, 1'b0, 1'b0, 16'h1234, 1'b0, 0, 0);
    do_access(2'b11, 'h20, 1'b0, 1'b1, 16'hFFEE, 1'b0, 0, 0);
    do_access(2'b10, 'h20, 1'b1, 1'b1, 16'h0000, 1'b0, 0, 0);
    do_access(2'b11, 'h20, 1'b1, 1'b1, 16'h5555, 1'b0, 0, 0);
    do_access(2'b00, 'h20, 1'b1, 1'b1, 16'h0000, 1'b0, 0, 0);

    // aliasing through ignored upper address bits
    do_access(2'b11, 'h005, 1'b0, 1'b0, 16'hBEEF, 1'b0, 0, 0);
    do_access(2'b10, 'h405, 1'b1, 1'b1, 16'h0000, 1'b0, 0, 0);

    // cpuena held while clk28_en stays low, then request held past completion
    do_access(2'b10, 'h10, 1'b1, 1'b1, 16'h0000, 1'b0, 20, 0);
    do_access(2'b10, 'h20, 1'b1, 1'b1, 16'h0000, 1'b0, 0, 6);

    // reset one cycle into a write must leave memory untouched
    do_access(2'b11, 'h40, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 0);
    @(posedge sysclk); #1;
    clk28_en = 1'b1;
    cpuAddr  = 25'h40;
    cpustate = 4'b0011;
    cpuL     = 1'b0;
    cpuU     = 1'b0;
    cpuWR    = 16'h0F0F;
    @(posedge sysclk); #1;
    reset_in = 1'b1;
    @(posedge sysclk); #1;
    reset_in = 1'b0;
    cpustate = 4'b0101;
    model_reset();
    @(negedge sysclk);
    chk("abort_cpuena", 32'(cpuena), 0);
    chk("abort_cpuRD", 32'(cpuRD), 0);
    chk("abort_acc_count", 32'(acc_count), 0);
    do_access(2'b10, 'h40, 1'b1, 1'b1, 16'h0000, 1'b0, 0, 0);

    // longword read followed by its neighbour, then a write that must drop the prefetch
    do_access(2'b11, 'h30, 1'b0, 1'b0, 16'h3030, 1'b0, 0, 0);
    do_access(2'b11, 'h31, 1'b0, 1'b0, 16'h3131, 1'b0, 0, 0);
    do_access(2'b00, 'h30, 1'b1, 1'b1, 16'h0000, 1'b1, 0, 0);
    do_access(2'b10, 'h31, 1'b1, 1'b1, 16'h0000, 1'b0, 0, 0);
    do_access(2'b10, 'h30, 1'b1, 1'b1, 16'h0000, 1'b1, 0, 0);
    do_access(2'b11, 'h31, 1'b0, 1'b0, 16'h7777, 1'b0, 0, 0);
    do_access(2'b10, 'h31, 1'b1, 1'b1, 16'h0000, 1'b0, 0, 0);

    // randomized traffic over a small pool of pre-written words
    for (int p = 0; p < 16; p++)
      do_access(2'b11, 'h100 + p, 1'b0, 1'b0, 16'($urandom), 1'b0, 0, 0);
    for (int n = 0; n < 60; n++) begin
      int          w;
      int          r;
      logic [1:0]  kind;
      w = 'h100 + int'($urandom % 16) + DEPTH * int'($urandom % 4096);
      r = int'($urandom % 3);
      kind = (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : 2'b11;
      do_access(kind, w, 1'($urandom % 2), 1'($urandom % 2), 16'($urandom), 1'($urandom % 2),
                ($urandom % 8 == 0) ? 3 : 0, ($urandom % 8 == 0) ? 2 : 0);
    end

    for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge sysclk);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
